// File: rtl/bin_to_bcd_seq_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq_pkg
// Shared definitions for the sequential binary-to-BCD converter:
//   - converter FSM state encoding (2 bits)
//   - BCD digit width and the blank code understood by hex_to_7seg
//   - double-dabble per-digit adjust helper
// ---------------------------------------------------------------------------
package bin_to_bcd_seq_pkg;

    localparam int         DIG_W     = 4;
    localparam logic [3:0] BCD_BLANK = 4'd10;
    localparam logic [3:0] BCD_NINE  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    // Double-dabble correction: a digit of 5 or more would become >= 10 after
    // the next shift, so pre-add 3. The result stays inside the 4-bit digit.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: add 3 when the digit is >= 5.
// Ports:
//   din   in  4  BCD digit before the shift
//   dout  out 4  corrected digit, ready to be shifted left by one
// ---------------------------------------------------------------------------
module bcd_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [DIG_W-1:0] din,
    output logic [DIG_W-1:0] dout
);

    assign dout = dabble_adj(din);

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential double-dabble converter: binary value (ms) -> NDIG BCD digits,
// one shift per clock. Start/busy/done handshake; the digit outputs are
// registered and only change on the cycle oDONE pulses, so a display fed from
// oDIG never sees a partially converted value.
//
// Parameters:
//   IN_W  input binary width (1..16)
//   NDIG  number of BCD output digits; values above 10**NDIG-1 saturate
//
// Ports:
//   iCLK    in   1       clock
//   iRST_N  in   1       asynchronous active-low reset
//   iBIN    in   IN_W    binary value, sampled only when a start is accepted
//   iSTART  in   1       conversion request (level or pulse)
//   oBUSY   out  1       conversion in progress
//   oDONE   out  1       one-cycle pulse: new digits valid
//   oOVF    out  1       last accepted value exceeded 10**NDIG-1 (saturated)
//   oDIG    out  4*NDIG  BCD digits, [3:0] = least significant
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//   non-zero digit are output as BCD_BLANK (digit 0 is never blanked, and a
//   saturated result is never blanked).
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int IN_W = 14,
    parameter int NDIG = 4
)(
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [IN_W-1:0]         iBIN,
    input  logic                    iSTART,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic                    oOVF,
    output logic [DIG_W*NDIG-1:0]   oDIG
);

    localparam int MAX_VAL = 10**NDIG - 1;
    localparam int BCD_W   = DIG_W * NDIG;
    localparam int CNT_W   = $clog2(IN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
    localparam logic [BCD_W-1:0] ALL_NINES = {NDIG{BCD_NINE}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic               spill_q, spill_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   dig_q, dig_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   dig_fmt;
    logic               in_ovf;
    logic               sat;

    assign in_ovf = (32'(iBIN) > 32'(MAX_VAL));

    // A bit falling out of the top digit can only happen for an out-of-range
    // input; it is folded into the saturation decision so the top adjust bit
    // has a defined meaning rather than being silently discarded.
    assign sat = ovf_pend_q | spill_q;

    // One adjust unit per digit, all operating on the current BCD field.
    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (bcd_q[gi*DIG_W +: DIG_W]),
                .dout (bcd_adj[gi*DIG_W +: DIG_W])
            );
        end
    endgenerate

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant digit down; blank zeros until the first
    // non-zero digit is seen. Digit 0 is excluded so a value of 0 shows "0".
    always_comb begin
        logic seen;
        seen    = 1'b0;
        dig_fmt = bcd_q;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (!seen && (bcd_q[i*DIG_W +: DIG_W] == 4'd0)) begin
                dig_fmt[i*DIG_W +: DIG_W] = BCD_BLANK;
            end else begin
                seen = 1'b1;
            end
        end
    end
`else
    assign dig_fmt = bcd_q;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        ovf_pend_d = ovf_pend_q;
        spill_d    = spill_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ovf_d      = ovf_q;
        dig_d      = dig_q;

        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    bin_d      = iBIN;
                    bcd_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = in_ovf;
                    spill_d    = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_SHIFT;
                end
            end

            S_SHIFT: begin
                // Adjust first, then shift the {bcd, bin} register left by one.
                bcd_d   = {bcd_adj[BCD_W-2:0], bin_q[IN_W-1]};
                bin_d   = bin_q << 1;
                spill_d = spill_q | bcd_adj[BCD_W-1];
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                dig_d   = sat ? ALL_NINES : dig_fmt;
                ovf_d   = ovf_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            ovf_pend_q <= 1'b0;
            spill_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            dig_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            ovf_pend_q <= ovf_pend_d;
            spill_q    <= spill_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            dig_q      <= dig_d;
        end
    end

    assign oBUSY = busy_q;
    assign oDONE = done_q;
    assign oOVF  = ovf_q;
    assign oDIG  = dig_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq at default parameters (IN_W=14,
// NDIG=4). Expected results come from a div/mod reference model, are queued
// when a start is driven and compared when oDONE pulses.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        iCLK;
    logic        iRST_N;
    logic [13:0] iBIN;
    logic        iSTART;
    logic        oBUSY;
    logic        oDONE;
    logic        oOVF;
    logic [15:0] oDIG;

    bin_to_bcd_seq #(.IN_W(14), .NDIG(4)) dut (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .iBIN   (iBIN),
        .iSTART (iSTART),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE),
        .oOVF   (oOVF),
        .oDIG   (oDIG)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    typedef struct {
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.dig = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.dig = {4'((v / 1000) % 10), 4'((v / 100) % 10),
                     4'((v / 10) % 10),   4'(v % 10)};
            e.ovf = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
            if (v < 1000) e.dig[15:12] = 4'hA;
            if (v < 100)  e.dig[11:8]  = 4'hA;
            if (v < 10)   e.dig[7:4]   = 4'hA;
`endif
        end
        return e;
    endfunction

    task automatic test_reset;
        iRST_N = 1'b0;
        iSTART = 1'b0;
        iBIN   = '0;
        repeat (2) @(posedge iCLK);
        #1;
        n_cmp++;
        if ({oBUSY, oDONE, oOVF, oDIG} !== 19'd0) begin
            n_mis++;
            $display("FAIL reset_outputs: got busy=%b done=%b ovf=%b dig=%h, expected all 0",
                     oBUSY, oDONE, oOVF, oDIG);
        end
        @(negedge iCLK);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        n_cmp++;
        if (oBUSY !== 1'b0 || oDONE !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, expected 0 0", oBUSY, oDONE);
        end
        $display("reset: released, outputs idle");
    endtask

    // Single conversion with a one-cycle start pulse; checks latency, busy
    // length, hold of old digits while busy, result and done pulse width.
    task automatic test_single(input int v);
        exp_t        e;
        int          cyc;
        int          busy_n;
        bit          ok;
        bit          held;
        logic [15:0] dig0;
        logic        ovf0;
        iBIN   = 14'(v);
        iSTART = 1'b1;
        sb.push_back(model(v));
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        iBIN   = ~iBIN;            // changes while busy must be ignored
        dig0   = oDIG;
        ovf0   = oOVF;
        busy_n = int'(oBUSY);
        held   = 1'b1;
        cyc    = 0;
        ok     = 1'b0;
        while (cyc < 40) begin
            @(posedge iCLK);
            #1;
            cyc++;
            if (oDONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
            busy_n += int'(oBUSY);
            if (oDIG !== dig0 || oOVF !== ovf0) held = 1'b0;
        end
        e = sb.pop_front();
        n_cmp++;
        if (!ok) begin
            n_mis++;
            $display("FAIL single_done_timeout: value %0d, no oDONE within 40 cycles", v);
        end
        n_cmp++;
        if (cyc != 15) begin
            n_mis++;
            $display("FAIL single_latency: value %0d, got %0d cycles, expected 15", v, cyc);
        end
        n_cmp++;
        if (busy_n != 15) begin
            n_mis++;
            $display("FAIL single_busy_len: value %0d, busy %0d cycles, expected 15", v, busy_n);
        end
        n_cmp++;
        if (!held) begin
            n_mis++;
            $display("FAIL single_hold: value %0d, outputs changed before oDONE (was %h/%b)", v, dig0, ovf0);
        end
        n_cmp++;
        if (oDIG !== e.dig || oOVF !== e.ovf || oBUSY !== 1'b0) begin
            n_mis++;
            $display("FAIL single_result: value %0d, got dig=%h ovf=%b busy=%b, expected dig=%h ovf=%b busy=0",
                     v, oDIG, oOVF, oBUSY, e.dig, e.ovf);
        end
        @(posedge iCLK);
        #1;
        n_cmp++;
        if (oDONE !== 1'b0 || oDIG !== e.dig) begin
            n_mis++;
            $display("FAIL single_pulse: value %0d, cycle after done got done=%b dig=%h, expected 0 %h",
                     v, oDONE, oDIG, e.dig);
        end
        $display("single: in=%0d dig=%h ovf=%b latency=%0d", v, oDIG, oOVF, cyc);
    endtask

    task automatic test_basic;
        test_single(1234);
        test_single(4321);
    endtask

    task automatic test_overflow;
        test_single(16383);
        test_single(9999);
        test_single(10000);
    endtask

    task automatic test_zero_and_small;
        test_single(0);
        test_single(47);
        test_single(5);
        test_single(305);
    endtask

    // iSTART held high: a new conversion starts right after every oDONE.
    task automatic test_back_to_back;
        exp_t e;
        int   cyc;
        bit   ok;
        bit   extra;
        iBIN   = 14'd250;
        iSTART = 1'b1;
        repeat (4) sb.push_back(model(250));
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            ok  = 1'b0;
            while (cyc < 40) begin
                @(posedge iCLK);
                #1;
                cyc++;
                if (oDONE === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (k == 3) iSTART = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (!ok || cyc != 16) begin
                n_mis++;
                $display("FAIL b2b_interval: pulse %0d after %0d cycles (seen=%b), expected 16", k, cyc, ok);
            end
            n_cmp++;
            if (oDIG !== e.dig || oOVF !== e.ovf) begin
                n_mis++;
                $display("FAIL b2b_result: pulse %0d got dig=%h ovf=%b, expected dig=%h ovf=%b",
                         k, oDIG, oOVF, e.dig, e.ovf);
            end
            $display("b2b: pulse %0d in=250 dig=%h interval=%0d", k, oDIG, cyc);
            if (!ok) break;
        end
        extra = 1'b0;
        repeat (20) begin
            @(posedge iCLK);
            #1;
            if (oDONE === 1'b1 || oBUSY === 1'b1) extra = 1'b1;
        end
        n_cmp++;
        if (extra) begin
            n_mis++;
            $display("FAIL b2b_stop: activity after iSTART dropped, got busy/done, expected idle");
        end
    endtask

    // A start pulse during a conversion is neither accepted nor queued.
    task automatic test_ignore_busy_start;
        exp_t e;
        int   cyc;
        bit   ok;
        bit   extra;
        iBIN   = 14'd1234;
        iSTART = 1'b1;
        sb.push_back(model(1234));
        cyc = 0;
        ok  = 1'b0;
        while (cyc < 40) begin
            @(posedge iCLK);
            #1;
            cyc++;
            if (cyc == 1) iSTART = 1'b0;
            if (cyc == 5) begin
                iBIN   = 14'd999;
                iSTART = 1'b1;
            end
            if (cyc == 6) iSTART = 1'b0;
            if (oDONE === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        e = sb.pop_front();
        n_cmp++;
        if (!ok || cyc != 16) begin
            n_mis++;
            $display("FAIL ignore_latency: done after %0d edges (seen=%b), expected 16", cyc, ok);
        end
        n_cmp++;
        if (oDIG !== e.dig || oOVF !== e.ovf) begin
            n_mis++;
            $display("FAIL ignore_result: got dig=%h ovf=%b, expected dig=%h ovf=%b", oDIG, oOVF, e.dig, e.ovf);
        end
        extra = 1'b0;
        repeat (20) begin
            @(posedge iCLK);
            #1;
            if (oDONE === 1'b1 || oBUSY === 1'b1) extra = 1'b1;
        end
        n_cmp++;
        if (extra || oDIG !== e.dig) begin
            n_mis++;
            $display("FAIL ignore_not_queued: later activity or dig=%h, expected idle with %h", oDIG, e.dig);
        end
        $display("ignore: first=1234 second=999 (busy) dig=%h", oDIG);
    endtask

    // Asynchronous reset in the middle of a conversion aborts it.
    task automatic test_reset_mid;
        bit extra;
        iBIN   = 14'd8765;
        iSTART = 1'b1;
        sb.push_back(model(8765));
        @(posedge iCLK);
        #1;
        iSTART = 1'b0;
        repeat (7) @(posedge iCLK);
        #2;
        iRST_N = 1'b0;
        #1;
        n_cmp++;
        if ({oBUSY, oDONE, oOVF, oDIG} !== 19'd0) begin
            n_mis++;
            $display("FAIL midreset_outputs: got busy=%b done=%b ovf=%b dig=%h, expected all 0",
                     oBUSY, oDONE, oOVF, oDIG);
        end
        void'(sb.pop_front());
        @(posedge iCLK);
        @(negedge iCLK);
        iRST_N = 1'b1;
        extra  = 1'b0;
        repeat (20) begin
            @(posedge iCLK);
            #1;
            if (oDONE === 1'b1 || oBUSY === 1'b1) extra = 1'b1;
        end
        n_cmp++;
        if (extra) begin
            n_mis++;
            $display("FAIL midreset_no_done: aborted conversion produced busy/done, expected none");
        end
        $display("midreset: conversion of 8765 aborted");
        test_single(8765);
    endtask

    // Directed boundaries followed by random values, back-to-back.
    task automatic test_random;
        exp_t e;
        int   v;
        int   cyc;
        bit   ok;
        int   n_tot;
        int   dir_vals[11] = '{9998, 9999, 10000, 16383, 1, 9, 10, 99, 100, 999, 1000};
        n_tot  = 1500;
        v      = dir_vals[0];
        iBIN   = 14'(v);
        iSTART = 1'b1;
        sb.push_back(model(v));
        for (int i = 0; i < n_tot; i++) begin
            cyc = 0;
            ok  = 1'b0;
            while (cyc < 40) begin
                @(posedge iCLK);
                #1;
                cyc++;
                if (oDONE === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            e = sb.pop_front();
            n_cmp++;
            if (!ok || cyc != 16) begin
                n_mis++;
                $display("FAIL rand_interval: item %0d in=%0d done after %0d (seen=%b), expected 16", i, v, cyc, ok);
            end
            n_cmp++;
            if (oDIG !== e.dig || oOVF !== e.ovf) begin
                n_mis++;
                $display("FAIL rand_result: item %0d in=%0d got dig=%h ovf=%b, expected dig=%h ovf=%b",
                         i, v, oDIG, oOVF, e.dig, e.ovf);
            end
            $display("rand: item %0d in=%0d dig=%h ovf=%b", i, v, oDIG, oOVF);
            if (!ok) begin
                iSTART = 1'b0;
                break;
            end
            if (i == n_tot - 1) begin
                iSTART = 1'b0;
            end else begin
                if (i + 1 < 11)            v = dir_vals[i + 1];
                else if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 9999));
                else                       v = int'($urandom_range(0, 16383));
                iBIN = 14'(v);
                sb.push_back(model(v));
            end
        end
        sb.delete();
        repeat (3) @(posedge iCLK);
        #1;
        n_cmp++;
        if (oBUSY !== 1'b0) begin
            n_mis++;
            $display("FAIL rand_idle: busy=%b after last item, expected 0", oBUSY);
        end
    endtask

    initial begin
        iRST_N = 1'b0;
        iSTART = 1'b0;
        iBIN   = '0;
        test_reset;
        test_basic;
        test_overflow;
        test_zero_and_small;
        test_back_to_back;
        test_ignore_busy_start;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
